// File: rtl/dht_sensor_reader_if.sv
`timescale 1ns/1ps
// dht_sensor_reader_if: request/result bundle between the DHT reader and its consumer.
// The reader sits on the slave side; the display/alarm logic sits on the master side.
interface dht_sensor_reader_if;
  logic        trigger;
  logic [15:0] humidity;
  logic [15:0] temperature;
  logic        data_valid;
  logic        ready;
  logic        busy;
  logic        crc_err;
  logic        timeout_err;
  logic [7:0]  err_count;

  modport master (
    output trigger,
    input  humidity, temperature, data_valid, ready, busy, crc_err, timeout_err, err_count
  );

  modport slave (
    input  trigger,
    output humidity, temperature, data_valid, ready, busy, crc_err, timeout_err, err_count
  );
endinterface

// File: rtl/dht_sensor_reader.sv
`timescale 1ns/1ps
// dht_sensor_reader: single-wire DHT11/DHT22 reader. Issues the host start pulse,
// follows the sensor handshake, decodes the 40-bit frame by high-pulse width,
// validates the checksum and reports humidity/temperature with error strobes.
module dht_sensor_reader #(
  parameter int CLK_HZ        = 50_000_000,
  parameter int POLL_MS       = 2000,
  parameter int START_LOW_US  = 18000,
  parameter int BIT_THRESH_US = 40,
  parameter int TIMEOUT_US    = 200,
  parameter int DHT22_MODE    = 0
) (
  input  logic clk,
  input  logic rst,
  inout  wire  dht_data,
  dht_sensor_reader_if.slave bus
);

  localparam int US_DIV  = (CLK_HZ >= 2_000_000) ? (CLK_HZ / 1_000_000) : 1;
  localparam int DIV_W   = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int PH_MAX0 = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
  localparam int PH_MAX  = (PH_MAX0 > BIT_THRESH_US) ? PH_MAX0 : BIT_THRESH_US;
  localparam int PH_W    = $clog2(PH_MAX + 2);
  localparam int POLL_W  = $clog2(POLL_MS + 2);

  localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(US_DIV - 1);
  localparam logic [PH_W-1:0]   START_LAST  = PH_W'(START_LOW_US - 1);
  localparam logic [PH_W-1:0]   TIMEOUT_LIM = PH_W'(TIMEOUT_US);
  localparam logic [PH_W-1:0]   THRESH      = PH_W'(BIT_THRESH_US);
  localparam logic [POLL_W-1:0] POLL_LIM    = POLL_W'(POLL_MS);

  typedef enum logic [2:0] {
    S_IDLE, S_START_LOW, S_WAIT_RESP, S_RESP_LOW,
    S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH, S_CHECK
  } state_t;

  // Checksum of a received frame: low byte of the sum of the four data bytes
  function automatic logic [7:0] frame_sum(input logic [39:0] f);
    frame_sum = f[39:32] + f[31:24] + f[23:16] + f[15:8];
  endfunction

  // Error counter step that sticks at its maximum
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    if (v == 8'hFF) sat_inc = v;
    else            sat_inc = v + 8'd1;
  endfunction

  logic              sync_q_r, sync_r;
  logic [DIV_W-1:0]  div_cnt_r;
  logic              tick_r;
  state_t            state_r;
  logic [PH_W-1:0]   phase_cnt_r;
  logic [9:0]        ms_us_cnt_r;
  logic [POLL_W-1:0] poll_cnt_r;
  logic [5:0]        bit_cnt_r;
  logic [39:0]       shift_r;
  logic              rel_seen_r;
  logic              drive_low_r;
  logic [15:0]       humidity_r, temperature_r;
  logic              data_valid_r, ready_r, busy_r, crc_err_r, timeout_err_r;
  logic [7:0]        err_count_r;

  logic              start_s, sensing_s, timeout_s, bit_s, crc_ok_s;
  logic [PH_W-1:0]   phase_inc_s;

  // Open-drain pin: only ever pulls low, otherwise released
  assign dht_data = drive_low_r ? 1'b0 : 1'bz;

  assign start_s     = bus.trigger || (poll_cnt_r == POLL_LIM);
  assign sensing_s   = state_r inside {S_WAIT_RESP, S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH};
  assign timeout_s   = sensing_s && (phase_cnt_r >= TIMEOUT_LIM);
  assign bit_s       = (phase_cnt_r > THRESH);
  assign crc_ok_s    = (frame_sum(shift_r) == shift_r[7:0]);
  assign phase_inc_s = phase_cnt_r + PH_W'(tick_r);

  assign bus.humidity    = humidity_r;
  assign bus.temperature = temperature_r;
  assign bus.data_valid  = data_valid_r;
  assign bus.ready       = ready_r;
  assign bus.busy        = busy_r;
  assign bus.crc_err     = crc_err_r;
  assign bus.timeout_err = timeout_err_r;
  assign bus.err_count   = err_count_r;

  // Two-flop synchroniser; idles high like the pulled-up line
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q_r <= 1'b1;
      sync_r   <= 1'b1;
    end else begin
      sync_q_r <= dht_data;
      sync_r   <= sync_q_r;
    end
  end

  // One-cycle microsecond strobe every US_DIV clocks
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r <= '0;
      tick_r    <= 1'b0;
    end else if (div_cnt_r == DIV_LAST) begin
      div_cnt_r <= '0;
      tick_r    <= 1'b1;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
      tick_r    <= 1'b0;
    end
  end

  // Read sequencer: poll timing, handshake phases, bit capture, checksum and status
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= S_IDLE;
      phase_cnt_r   <= '0;
      ms_us_cnt_r   <= 10'd0;
      poll_cnt_r    <= '0;
      bit_cnt_r     <= 6'd0;
      shift_r       <= 40'd0;
      rel_seen_r    <= 1'b0;
      drive_low_r   <= 1'b0;
      humidity_r    <= 16'd0;
      temperature_r <= 16'd0;
      data_valid_r  <= 1'b0;
      ready_r       <= 1'b0;
      busy_r        <= 1'b0;
      crc_err_r     <= 1'b0;
      timeout_err_r <= 1'b0;
      err_count_r   <= 8'd0;
    end else begin
      data_valid_r  <= 1'b0;
      crc_err_r     <= 1'b0;
      timeout_err_r <= 1'b0;
      if (timeout_s) begin
        // Sensor went quiet: give up, keep the last good values, line stays released
        timeout_err_r <= 1'b1;
        err_count_r   <= sat_inc(err_count_r);
        state_r       <= S_IDLE;
        busy_r        <= 1'b0;
        phase_cnt_r   <= '0;
      end else begin
        case (state_r)
          S_IDLE: begin
            phase_cnt_r <= '0;
            if (start_s) begin
              state_r     <= S_START_LOW;
              drive_low_r <= 1'b1;
              busy_r      <= 1'b1;
              poll_cnt_r  <= '0;
              ms_us_cnt_r <= 10'd0;
              bit_cnt_r   <= 6'd0;
            end else if (tick_r) begin
              if (ms_us_cnt_r == 10'd999) begin
                ms_us_cnt_r <= 10'd0;
                if (poll_cnt_r != POLL_LIM) poll_cnt_r <= poll_cnt_r + POLL_W'(1);
              end else begin
                ms_us_cnt_r <= ms_us_cnt_r + 10'd1;
              end
            end
          end
          S_START_LOW: begin
            if (tick_r && (phase_cnt_r == START_LAST)) begin
              drive_low_r <= 1'b0;
              rel_seen_r  <= 1'b0;
              state_r     <= S_WAIT_RESP;
              phase_cnt_r <= '0;
            end else begin
              phase_cnt_r <= phase_inc_s;
            end
          end
          S_WAIT_RESP: begin
            // The synchroniser still shows our own start pulse for a couple of
            // cycles, so the line must be seen high before a low counts as ack.
            if (rel_seen_r && !sync_r) begin
              state_r     <= S_RESP_LOW;
              phase_cnt_r <= '0;
            end else begin
              phase_cnt_r <= phase_inc_s;
              if (sync_r) rel_seen_r <= 1'b1;
            end
          end
          S_RESP_LOW: begin
            if (sync_r) begin
              state_r     <= S_RESP_HIGH;
              phase_cnt_r <= '0;
            end else begin
              phase_cnt_r <= phase_inc_s;
            end
          end
          S_RESP_HIGH: begin
            if (!sync_r) begin
              state_r     <= S_BIT_LOW;
              phase_cnt_r <= '0;
            end else begin
              phase_cnt_r <= phase_inc_s;
            end
          end
          S_BIT_LOW: begin
            if (sync_r) begin
              state_r     <= S_BIT_HIGH;
              phase_cnt_r <= '0;
            end else begin
              phase_cnt_r <= phase_inc_s;
            end
          end
          S_BIT_HIGH: begin
            if (!sync_r) begin
              shift_r     <= {shift_r[38:0], bit_s};
              bit_cnt_r   <= bit_cnt_r + 6'd1;
              phase_cnt_r <= '0;
              if (bit_cnt_r == 6'd39) state_r <= S_CHECK;
              else                    state_r <= S_BIT_LOW;
            end else begin
              phase_cnt_r <= phase_inc_s;
            end
          end
          S_CHECK: begin
            if (crc_ok_s) begin
              if (DHT22_MODE != 0) begin
                humidity_r    <= shift_r[39:24];
                temperature_r <= shift_r[23:8];
              end else begin
                humidity_r    <= {8'h00, shift_r[39:32]};
                temperature_r <= {8'h00, shift_r[23:16]};
              end
              data_valid_r <= 1'b1;
              ready_r      <= 1'b1;
            end else begin
              crc_err_r   <= 1'b1;
              err_count_r <= sat_inc(err_count_r);
            end
            state_r     <= S_IDLE;
            busy_r      <= 1'b0;
            poll_cnt_r  <= '0;
            ms_us_cnt_r <= 10'd0;
            phase_cnt_r <= '0;
          end
          default: begin
            state_r     <= S_IDLE;
            drive_low_r <= 1'b0;
            busy_r      <= 1'b0;
            phase_cnt_r <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dht_sensor_reader.sv
`timescale 1ns/1ps
// tb_dht_sensor_reader: directed bench with a behavioural DHT sensor model.
// 1 MHz clock so one clock cycle equals one microsecond tick.
module tb_dht_sensor_reader;

  logic clk = 1'b0;
  always #500 clk = ~clk;

  logic rst;
  wire  line_a, line_b, line_c;
  logic sen_low_a, sen_low_b;

  pullup (line_a);
  pullup (line_b);
  pullup (line_c);
  assign line_a = sen_low_a ? 1'b0 : 1'bz;
  assign line_b = sen_low_b ? 1'b0 : 1'bz;

  dht_sensor_reader_if if_a ();
  dht_sensor_reader_if if_b ();
  dht_sensor_reader_if if_c ();

  dht_sensor_reader #(.CLK_HZ(1_000_000), .POLL_MS(5), .START_LOW_US(100), .BIT_THRESH_US(40),
                      .TIMEOUT_US(200), .DHT22_MODE(0))
    dut_a (.clk(clk), .rst(rst), .dht_data(line_a), .bus(if_a));

  dht_sensor_reader #(.CLK_HZ(1_000_000), .POLL_MS(5), .START_LOW_US(100), .BIT_THRESH_US(40),
                      .TIMEOUT_US(200), .DHT22_MODE(1))
    dut_b (.clk(clk), .rst(rst), .dht_data(line_b), .bus(if_b));

  // Short phases so that hundreds of timeouts fit in a few thousand cycles
  dht_sensor_reader #(.CLK_HZ(1_000_000), .POLL_MS(5), .START_LOW_US(2), .BIT_THRESH_US(40),
                      .TIMEOUT_US(3), .DHT22_MODE(0))
    dut_c (.clk(clk), .rst(rst), .dht_data(line_c), .bus(if_c));

  int n_checks = 0;
  int n_errors = 0;
  int dv_a = 0, crc_a = 0, to_a = 0, dv_b = 0;

  // Count status strobes so each test can check how many pulses it produced
  always @(negedge clk) begin
    if (if_a.data_valid)  dv_a  <= dv_a + 1;
    if (if_a.crc_err)     crc_a <= crc_a + 1;
    if (if_a.timeout_err) to_a  <= to_a + 1;
    if (if_b.data_valid)  dv_b  <= dv_b + 1;
  end

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] in_rng(input int v, input int lo, input int hi, input int nom);
    if (v >= lo && v <= hi) in_rng = 40'(nom);
    else                    in_rng = 40'(v);
  endfunction

  function automatic logic line_val(input int sel);
    case (sel)
      0:       line_val = line_a;
      1:       line_val = line_b;
      default: line_val = line_c;
    endcase
  endfunction

  task automatic set_low(input int sel, input logic v);
    if (sel == 0) sen_low_a = v;
    else          sen_low_b = v;
  endtask

  task automatic set_trig(input int sel, input logic v);
    case (sel)
      0:       if_a.trigger = v;
      1:       if_b.trigger = v;
      default: if_c.trigger = v;
    endcase
  endtask

  task automatic pulse(input int sel);
    @(negedge clk);
    set_trig(sel, 1'b1);
    @(negedge clk);
    set_trig(sel, 1'b0);
  endtask

  // Waits for the line to reach a level; n = cycles waited, -1 if the bound expired
  task automatic wait_for(input int sel, input logic level, input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (line_val(sel) == level) begin
        n = i;
        break;
      end
    end
  endtask

  // Sensor model: answers one host start pulse with a frame.
  // stop_bit >= 0: go silent (line released) before that bit; rst_bit >= 0: pulse rst there.
  task automatic sensor_read(input int sel, input logic [39:0] frame, input int stop_bit,
                             input int rst_bit, output int low_len, output int wait_n);
    int n;
    low_len = 0;
    wait_for(sel, 1'b0, 12000, wait_n);
    chk("host_start_seen", 40'(wait_n > 0), 40'd1);
    if (wait_n <= 0) return;
    low_len = 1;
    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      if (line_val(sel) == 1'b1) break;
      low_len++;
    end
    repeat (30) @(negedge clk);
    set_low(sel, 1'b1);
    repeat (80) @(negedge clk);
    set_low(sel, 1'b0);
    repeat (80) @(negedge clk);
    for (int b = 0; b < 40; b++) begin
      if (b == stop_bit) return;
      if (b == rst_bit) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_humidity", 40'(if_a.humidity), 40'd0);
        chk("rst_mid_temperature", 40'(if_a.temperature), 40'd0);
        chk("rst_mid_ready", 40'(if_a.ready), 40'd0);
        chk("rst_mid_busy", 40'(if_a.busy), 40'd0);
        chk("rst_mid_err_count", 40'(if_a.err_count), 40'd0);
        chk("rst_mid_line", 40'(line_a), 40'd1);
        rst = 1'b0;
        return;
      end
      set_low(sel, 1'b1);
      repeat (50) @(negedge clk);
      set_low(sel, 1'b0);
      n = frame[39 - b] ? 70 : 27;
      repeat (n) @(negedge clk);
    end
    set_low(sel, 1'b1);
    repeat (50) @(negedge clk);
    set_low(sel, 1'b0);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int   len, wn, n, d0, c0, t0;
    logic ok_all;
    rst = 1'b1;
    sen_low_a = 1'b0;
    sen_low_b = 1'b0;
    if_a.trigger = 1'b0;
    if_b.trigger = 1'b0;
    if_c.trigger = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_humidity", 40'(if_a.humidity), 40'd0);
    chk("rst_temperature", 40'(if_a.temperature), 40'd0);
    chk("rst_ready", 40'(if_a.ready), 40'd0);
    chk("rst_busy", 40'(if_a.busy), 40'd0);
    chk("rst_err_count", 40'(if_a.err_count), 40'd0);
    chk("rst_data_valid", 40'(if_a.data_valid), 40'd0);
    chk("rst_line", 40'(line_a), 40'd1);
    rst = 1'b0;

    // 1: good DHT11 frame on demand
    d0 = dv_a; c0 = crc_a;
    pulse(0);
    sensor_read(0, 40'h37_00_19_00_50, -1, -1, len, wn);
    repeat (5) @(negedge clk);
    chk("t1_start_low_us", in_rng(len, 99, 101, 100), 40'd100);
    chk("t1_humidity", 40'(if_a.humidity), 40'h0037);
    chk("t1_temperature", 40'(if_a.temperature), 40'h0019);
    chk("t1_valid_pulses", 40'(dv_a - d0), 40'd1);
    chk("t1_ready", 40'(if_a.ready), 40'd1);
    chk("t1_err_count", 40'(if_a.err_count), 40'd0);
    chk("t1_busy", 40'(if_a.busy), 40'd0);

    // 2: bad checksum keeps previous values
    d0 = dv_a; c0 = crc_a;
    pulse(0);
    sensor_read(0, 40'h37_00_19_00_51, -1, -1, len, wn);
    repeat (5) @(negedge clk);
    chk("t2_crc_pulses", 40'(crc_a - c0), 40'd1);
    chk("t2_valid_pulses", 40'(dv_a - d0), 40'd0);
    chk("t2_humidity", 40'(if_a.humidity), 40'h0037);
    chk("t2_temperature", 40'(if_a.temperature), 40'h0019);
    chk("t2_err_count", 40'(if_a.err_count), 40'd1);

    // 3: no acknowledge from the sensor
    t0 = to_a;
    pulse(0);
    wait_for(0, 1'b1, 300, wn);
    chk("t3_release_seen", 40'(wn > 0), 40'd1);
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (if_a.timeout_err) begin
        n = i;
        break;
      end
    end
    chk("t3_timeout_delay", in_rng(n, 198, 204, 200), 40'd200);
    repeat (3) @(negedge clk);
    chk("t3_timeout_pulses", 40'(to_a - t0), 40'd1);
    chk("t3_busy", 40'(if_a.busy), 40'd0);
    chk("t3_line", 40'(line_a), 40'd1);
    chk("t3_err_count", 40'(if_a.err_count), 40'd2);
    chk("t3_ready_held", 40'(if_a.ready), 40'd1);

    // 4: stall after bit 17, then the automatic poll succeeds
    pulse(0);
    sensor_read(0, 40'h41_00_17_00_58, 17, -1, len, wn);
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (if_a.timeout_err) begin
        n = i;
        break;
      end
    end
    chk("t4_stall_timeout", 40'(n > 0), 40'd1);
    d0 = dv_a;
    sensor_read(0, 40'h41_00_17_00_58, -1, -1, len, wn);
    repeat (5) @(negedge clk);
    chk("t4_poll_delay", in_rng(wn, 4995, 5010, 5000), 40'd5000);
    chk("t4_valid_pulses", 40'(dv_a - d0), 40'd1);
    chk("t4_humidity", 40'(if_a.humidity), 40'h0041);
    chk("t4_temperature", 40'(if_a.temperature), 40'h0017);
    chk("t4_err_count", 40'(if_a.err_count), 40'd3);

    // 5: DHT22 format with negative temperature
    d0 = dv_b;
    pulse(1);
    sensor_read(1, 40'h02_8C_80_65_73, -1, -1, len, wn);
    repeat (5) @(negedge clk);
    chk("t5_humidity", 40'(if_b.humidity), 40'h028C);
    chk("t5_temperature", 40'(if_b.temperature), 40'h8065);
    chk("t5_valid_pulses", 40'(dv_b - d0), 40'd1);
    chk("t5_ready", 40'(if_b.ready), 40'd1);

    // 6: reset mid-frame, then a clean read
    pulse(0);
    sensor_read(0, 40'h2A_00_1C_00_46, -1, 20, len, wn);
    repeat (10) @(negedge clk);
    d0 = dv_a;
    pulse(0);
    sensor_read(0, 40'h2A_00_1C_00_46, -1, -1, len, wn);
    repeat (5) @(negedge clk);
    chk("t6_humidity", 40'(if_a.humidity), 40'h002A);
    chk("t6_temperature", 40'(if_a.temperature), 40'h001C);
    chk("t6_valid_pulses", 40'(dv_a - d0), 40'd1);
    chk("t6_ready", 40'(if_a.ready), 40'd1);
    chk("t6_err_count", 40'(if_a.err_count), 40'd0);

    // Error counter saturation on the fast instance
    ok_all = 1'b1;
    for (int i = 0; i < 300; i++) begin
      pulse(2);
      n = -1;
      for (int k = 1; k <= 60; k++) begin
        @(negedge clk);
        if (!if_c.busy) begin
          n = k;
          break;
        end
      end
      if (n < 0) ok_all = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("sat_reads_finished", 40'(ok_all), 40'd1);
    chk("sat_err_count", 40'(if_c.err_count), 40'd255);
    chk("sat_line_c", 40'(line_c), 40'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
